// File: rtl/uart_ctrl_pkg.sv
// Shared UART controller constants: scheduler FSM encodings and counter widths.
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARB      = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_WRITE    = 3'd3,
        ST_SETTLE   = 3'd4
    } state_e;

    localparam int LOCK_CNT_W   = 16;
    localparam int SETTLE_CNT_W = 8;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester byte bus, UART write port and status for the TX scheduler.
// slave = scheduler side, master = requesters plus UART ready.
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]         REQ_VALID;
    logic [8*NUM_REQ-1:0]       REQ_DATA;
    logic [NUM_REQ-1:0]         REQ_LAST;
    logic [NUM_REQ-1:0]         REQ_READY;
    logic                       TXRDY;
    logic                       CSN;
    logic                       WEN;
    logic [7:0]                 DATA_IN;
    logic [$clog2(NUM_REQ)-1:0] GRANT_ID;
    logic                       BUSY;
    logic                       LOCK_ABORT;

    modport master (
        output REQ_VALID, REQ_DATA, REQ_LAST, TXRDY,
        input  REQ_READY, CSN, WEN, DATA_IN, GRANT_ID, BUSY, LOCK_ABORT
    );

    modport slave (
        input  REQ_VALID, REQ_DATA, REQ_LAST, TXRDY,
        output REQ_READY, CSN, WEN, DATA_IN, GRANT_ID, BUSY, LOCK_ABORT
    );
endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping; zero latency.
module uart_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic [$clog2(N)-1:0] gnt,
    output logic                 any
);
    logic [$clog2(N)-1:0] idx;

    always_comb begin
        gnt = '0;
        any = 1'b0;
        idx = '0;
        for (int k = 1; k <= N; k++) begin
            idx = $clog2(N)'((int'(last_grant) + k) % N);
            if (!any && req[idx]) begin
                gnt = idx;
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler feeding a UART; a packet holds the grant until LAST or lock timeout.
// First byte strobes 2 cycles after VALID; requesters stall until their one-cycle REQ_READY pulse.
module uart_tx_sched
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int SETTLE_CYC   = 2
) (
    input  logic           CLK,
    input  logic           RESET_N,
    uart_tx_sched_if.slave bus
);
    localparam int IDW = $clog2(NUM_REQ);

    state_e                  state_q, state_d;
    logic [IDW-1:0]          grant_q, grant_d;
    logic [IDW-1:0]          last_grant_q, last_grant_d;
    logic [LOCK_CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic                    last_byte_q, last_byte_d;
    logic                    csn_q, csn_d;
    logic                    wen_q, wen_d;
    logic                    busy_q, busy_d;
    logic                    abort_q, abort_d;
    logic [7:0]              data_q, data_d;
    logic [NUM_REQ-1:0]      ready_q, ready_d;

    logic [IDW-1:0] arb_gnt, sel;
    logic           arb_any, sel_vld, sel_last;
    logic [7:0]     sel_dat;

    uart_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req        (bus.REQ_VALID),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt),
        .any        (arb_any)
    );

    // In ARB the fresh winner is examined directly, so a ready UART is written without a WAIT_RDY cycle.
    assign sel      = (state_q == ST_ARB) ? arb_gnt : grant_q;
    assign sel_vld  = bus.REQ_VALID[sel];
    assign sel_last = bus.REQ_LAST[sel];
    assign sel_dat  = bus.REQ_DATA[int'(sel)*8 +: 8];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        lock_cnt_d   = lock_cnt_q;
        settle_cnt_d = settle_cnt_q;
        last_byte_d  = last_byte_q;
        data_d       = data_q;
        csn_d        = 1'b1;
        wen_d        = 1'b1;
        ready_d      = '0;
        abort_d      = 1'b0;
        case (state_q)
            ST_IDLE: if (|bus.REQ_VALID) state_d = ST_ARB;
            ST_ARB: begin
                if (arb_any) begin
                    grant_d      = arb_gnt;
                    last_grant_d = arb_gnt;
                    lock_cnt_d   = '0;
                    state_d      = ST_WAIT_RDY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_RDY: begin
                // Only an absent owner ages the lock; a slow UART never does.
                if (!sel_vld) begin
                    if (lock_cnt_q == LOCK_CNT_W'(LOCK_TIMEOUT - 1)) begin
                        abort_d    = 1'b1;
                        lock_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end else begin
                    lock_cnt_d = '0;
                end
            end
            ST_WRITE: begin
                settle_cnt_d = '0;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_CNT_W'(SETTLE_CYC - 1)) begin
                    state_d = last_byte_q ? ST_IDLE : ST_WAIT_RDY;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q == ST_ARB || state_q == ST_WAIT_RDY) && sel_vld && bus.TXRDY) begin
            state_d      = ST_WRITE;
            csn_d        = 1'b0;
            wen_d        = 1'b0;
            ready_d[sel] = 1'b1;
            data_d       = sel_dat;
            last_byte_d  = sel_last;
            lock_cnt_d   = '0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDW'(NUM_REQ - 1);
            lock_cnt_q   <= '0;
            settle_cnt_q <= '0;
            last_byte_q  <= 1'b0;
            data_q       <= '0;
            csn_q        <= 1'b1;
            wen_q        <= 1'b1;
            ready_q      <= '0;
            busy_q       <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            lock_cnt_q   <= lock_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            last_byte_q  <= last_byte_d;
            data_q       <= data_d;
            csn_q        <= csn_d;
            wen_q        <= wen_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            abort_q      <= abort_d;
        end
    end

    assign bus.CSN        = csn_q;
    assign bus.WEN        = wen_q;
    assign bus.DATA_IN    = data_q;
    assign bus.REQ_READY  = ready_q;
    assign bus.GRANT_ID   = grant_q;
    assign bus.BUSY       = busy_q;
    assign bus.LOCK_ABORT = abort_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed scenarios for uart_tx_sched; expected strobes and aborts are queued by the stimulus
// and a free-running monitor pops and compares them whenever the DUT strobes or aborts.
module tb_uart_tx_sched;
    localparam int NR = 4;
    localparam int LT = 16;
    localparam int SC = 2;

    logic CLK;
    logic RESET_N;

    uart_tx_sched_if #(.NUM_REQ(NR)) bus ();

    uart_tx_sched #(.NUM_REQ(NR), .LOCK_TIMEOUT(LT), .SETTLE_CYC(SC)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    typedef struct {
        int         id;
        logic [7:0] dat;
        logic       last;
        int         t_exp;
    } item_t;

    item_t         pend[$];
    item_t         exp_q[$];
    int            abort_q[$];
    int            cyc;
    int            n_checks;
    int            n_errors;
    logic [7:0]    last_written;
    logic [NR-1:0] hold;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge CLK);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic update_drives();
        logic [NR-1:0]   v;
        logic [NR-1:0]   l;
        logic [8*NR-1:0] d;
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < NR; i++) begin
            for (int k = 0; k < pend.size(); k++) begin
                if (pend[k].id == i) begin
                    v[i]       = !hold[i];
                    d[8*i +: 8] = pend[k].dat;
                    l[i]       = pend[k].last;
                    break;
                end
            end
        end
        bus.REQ_VALID = v;
        bus.REQ_DATA  = d;
        bus.REQ_LAST  = l;
    endtask

    task automatic tick();
        @(negedge CLK);
        for (int i = 0; i < NR; i++) begin
            if (bus.REQ_READY[i]) begin
                for (int k = 0; k < pend.size(); k++) begin
                    if (pend[k].id == i) begin
                        pend.delete(k);
                        break;
                    end
                end
            end
        end
        update_drives();
    endtask

    task automatic tick_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic send(input int id, input logic [7:0] dat, input logic last, input int t_exp);
        item_t it;
        it.id    = id;
        it.dat   = dat;
        it.last  = last;
        it.t_exp = t_exp;
        pend.push_back(it);
        exp_q.push_back(it);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.BUSY !== 1'b0) && n < 1000) begin
            tick();
            n++;
        end
        chk({name, "_pending"}, exp_q.size(), 0);
        chk({name, "_busy"}, bus.BUSY, 0);
    endtask

    task automatic do_reset();
        #2 RESET_N = 1'b0;
        pend.delete();
        exp_q.delete();
        abort_q.delete();
        hold         = '0;
        last_written = '0;
        update_drives();
        tick();
        tick();
        RESET_N = 1'b1;
    endtask

    // Monitor: every strobe must match the head of the expected queue; outside strobes the port is quiet.
    initial begin
        item_t e;
        int    ea;
        forever begin
            @(negedge CLK);
            if (RESET_N === 1'b1) begin
                if (bus.LOCK_ABORT !== 1'b0) begin
                    if (abort_q.size() == 0) begin
                        chk("unexpected_abort", bus.LOCK_ABORT, 0);
                    end else begin
                        ea = abort_q.pop_front();
                        chk("abort_cycle", cyc, ea);
                    end
                end
                if (bus.CSN === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_strobe", bus.CSN, 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("strobe_data", bus.DATA_IN, e.dat);
                        chk("strobe_grant", bus.GRANT_ID, e.id);
                        chk("strobe_ready", bus.REQ_READY, 1 << e.id);
                        chk("strobe_wen", bus.WEN, 0);
                        if (e.t_exp >= 0) chk("strobe_cycle", cyc, e.t_exp);
                        last_written = e.dat;
                    end
                end else begin
                    chk("idle_csn", bus.CSN, 1);
                    chk("idle_wen", bus.WEN, 1);
                    chk("idle_ready", bus.REQ_READY, 0);
                    chk("idle_data_hold", bus.DATA_IN, last_written);
                end
            end
        end
    end

    initial begin
        int c;
        n_checks      = 0;
        n_errors      = 0;
        hold          = '0;
        last_written  = '0;
        bus.REQ_VALID = '0;
        bus.REQ_DATA  = '0;
        bus.REQ_LAST  = '0;
        bus.TXRDY     = 1'b1;
        RESET_N       = 1'b1;
        #1 RESET_N    = 1'b0;

        @(negedge CLK);
        #1;
        chk("rst_csn", bus.CSN, 1);
        chk("rst_wen", bus.WEN, 1);
        chk("rst_data", bus.DATA_IN, 0);
        chk("rst_ready", bus.REQ_READY, 0);
        chk("rst_grant", bus.GRANT_ID, 0);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_abort", bus.LOCK_ABORT, 0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Three-byte packet from requester 0: strobes 4 cycles apart, idle 3 cycles after the last.
        tick();
        c = cyc;
        send(0, 8'h41, 1'b0, c + 2);
        send(0, 8'h42, 1'b0, c + 6);
        send(0, 8'h43, 1'b1, c + 10);
        update_drives();
        tick_until(c + 12);
        chk("t1_busy_settle", bus.BUSY, 1);
        tick();
        chk("t1_busy_idle", bus.BUSY, 0);
        wait_idle("t1");

        // All requesters valid with single-byte packets right after reset.
        do_reset();
        tick();
        c = cyc;
        send(0, 8'hA0, 1'b1, c + 2);
        send(1, 8'hA1, 1'b1, -1);
        send(2, 8'hA2, 1'b1, -1);
        send(3, 8'hA3, 1'b1, -1);
        send(0, 8'hA4, 1'b1, -1);
        update_drives();
        wait_idle("t2");

        // Requester 2 arrives while requester 1 holds the lock.
        tick();
        send(1, 8'hB0, 1'b0, -1);
        send(1, 8'hB1, 1'b0, -1);
        send(1, 8'hB2, 1'b1, -1);
        update_drives();
        repeat (3) tick();
        send(2, 8'hC0, 1'b1, -1);
        update_drives();
        wait_idle("t3");

        // Requester 0 goes silent mid-packet; lock aborts and requester 1 takes over.
        tick();
        c = cyc;
        send(0, 8'hD0, 1'b0, c + 2);
        send(1, 8'hE0, 1'b1, c + 23);
        send(0, 8'hD1, 1'b1, -1);
        abort_q.push_back(c + 21);
        update_drives();
        tick_until(c + 2);
        hold[0] = 1'b1;
        update_drives();
        tick_until(c + 24);
        hold[0] = 1'b0;
        update_drives();
        wait_idle("t4");

        // UART not ready for 500 cycles: no strobe, no abort, write the cycle after TXRDY rises.
        tick();
        c = cyc;
        bus.TXRDY = 1'b0;
        send(3, 8'hF0, 1'b1, c + 501);
        update_drives();
        tick_until(c + 500);
        bus.TXRDY = 1'b1;
        wait_idle("t5");

        // Reset during WRITE releases the strobe without a clock edge.
        tick();
        c = cyc;
        send(2, 8'h5A, 1'b1, c + 2);
        update_drives();
        tick_until(c + 2);
        chk("pre_reset_csn", bus.CSN, 0);
        #2 RESET_N = 1'b0;
        #1;
        chk("async_rst_csn", bus.CSN, 1);
        chk("async_rst_wen", bus.WEN, 1);
        chk("async_rst_ready", bus.REQ_READY, 0);
        chk("async_rst_data", bus.DATA_IN, 0);
        chk("async_rst_grant", bus.GRANT_ID, 0);
        chk("async_rst_busy", bus.BUSY, 0);
        chk("async_rst_abort", bus.LOCK_ABORT, 0);
        pend.delete();
        exp_q.delete();
        last_written = '0;
        update_drives();
        tick();
        tick();
        RESET_N = 1'b1;

        // Round-robin pointer restarts after reset: requester 1 wins over 3.
        tick();
        c = cyc;
        send(1, 8'h77, 1'b1, c + 2);
        send(3, 8'h66, 1'b1, -1);
        update_drives();
        wait_idle("t6");

        repeat (3) tick();
        chk("exp_drained", exp_q.size(), 0);
        chk("abort_drained", abort_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
